// File: rtl/arp_pkg.sv
// Shared definitions for the ARP request arbiter and related blocks.
package arp_pkg;

  localparam int IP_W  = 32;
  localparam int MAC_W = 48;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_TOUT = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_prio_sel.sv
// Combinational round-robin selector: picks the first asserted request at or
// after the pointer, wrapping around, and reports it one-hot and encoded.
module rr_prio_sel #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  // Scan from the pointer upward with wrap; the first hit wins.
  always_comb begin
    int   j;
    logic found;
    j        = 0;
    found    = 1'b0;
    o_onehot = '0;
    o_idx    = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      if (!found && i_req[j]) begin
        found       = 1'b1;
        o_onehot[j] = 1'b1;
        o_idx       = IW'(j);
      end
    end
    o_any = found;
  end

endmodule

// File: rtl/arp_req_arb.sv
// Shares one ARP lookup port between PORTS requesters. Round-robin grant,
// single lookup in flight, response routed back to the issuing requester,
// optional watchdog that answers a stalled lookup with an error.
module arp_req_arb
  import arp_pkg::*;
#(
  parameter int PORTS         = 4,
  parameter int RESP_TIMEOUT  = 0,
  parameter int TIMEOUT_WIDTH = 16,
  localparam int GW           = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PORTS-1:0]       s_arp_request_valid,
  output logic [PORTS-1:0]       s_arp_request_ready,
  input  logic [PORTS*IP_W-1:0]  s_arp_request_ip,
  output logic [PORTS-1:0]       s_arp_response_valid,
  input  logic [PORTS-1:0]       s_arp_response_ready,
  output logic [PORTS-1:0]       s_arp_response_error,
  output logic [PORTS*MAC_W-1:0] s_arp_response_mac,
  output logic                   m_arp_request_valid,
  input  logic                   m_arp_request_ready,
  output logic [IP_W-1:0]        m_arp_request_ip,
  input  logic                   m_arp_response_valid,
  output logic                   m_arp_response_ready,
  input  logic                   m_arp_response_error,
  input  logic [MAC_W-1:0]       m_arp_response_mac,
  output logic                   busy,
  output logic [GW-1:0]          grant
);

  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST =
    (RESP_TIMEOUT == 0) ? '0 : TIMEOUT_WIDTH'(RESP_TIMEOUT - 1);

  arb_state_t               r_state, w_next;
  logic [IP_W-1:0]          r_ip;
  logic [GW-1:0]            r_grant, r_ptr, w_ptr_next;
  logic [TIMEOUT_WIDTH-1:0] r_wd;
  logic [PORTS-1:0]         w_sel_oh;
  logic [GW-1:0]            w_sel_idx;
  logic                     w_sel_any;
  logic                     w_req_hs, w_mreq_hs, w_resp_done, w_wd_expire;

  rr_prio_sel #(.N(PORTS), .IW(GW)) u_sel (
    .i_req    (s_arp_request_valid),
    .i_ptr    (r_ptr),
    .o_onehot (w_sel_oh),
    .o_idx    (w_sel_idx),
    .o_any    (w_sel_any)
  );

  assign w_req_hs    = (r_state == S_IDLE) && w_sel_any;
  assign w_mreq_hs   = (r_state == S_REQ) && m_arp_request_ready;
  assign w_resp_done = ((r_state == S_WAIT) && m_arp_response_valid &&
                        s_arp_response_ready[r_grant]) ||
                       ((r_state == S_TOUT) && s_arp_response_ready[r_grant]);
  assign w_wd_expire = (RESP_TIMEOUT != 0) && (r_wd == WD_LAST);
  assign w_ptr_next  = (r_grant == GW'(PORTS - 1)) ? '0 : r_grant + GW'(1);
  assign busy        = (r_state != S_IDLE);
  assign grant       = r_grant;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Grant, round-robin pointer and watchdog counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grant <= '0;
      r_ptr   <= '0;
      r_wd    <= '0;
    end else begin
      if (w_req_hs) r_grant <= w_sel_idx;
      if (w_mreq_hs)                r_wd <= '0;
      else if (r_state == S_WAIT)   r_wd <= r_wd + TIMEOUT_WIDTH'(1);
      if (w_resp_done) r_ptr <= w_ptr_next;
    end
  end

  // Latch the winning requester's IP; held stable through REQ.
  always_ff @(posedge clk) begin
    if (w_req_hs) r_ip <= s_arp_request_ip[w_sel_idx*IP_W +: IP_W];
  end

  // Next state and all handshake/routing outputs.
  always_comb begin
    w_next               = r_state;
    s_arp_request_ready  = '0;
    s_arp_response_valid = '0;
    s_arp_response_error = '0;
    s_arp_response_mac   = '0;
    m_arp_request_valid  = 1'b0;
    m_arp_request_ip     = '0;
    m_arp_response_ready = 1'b1;
    case (r_state)
      S_IDLE: begin
        // Ready is masked while reset is held so no requester sees a
        // handshake that the registers will not honour.
        if (rst_n) s_arp_request_ready = w_sel_oh;
        if (w_sel_any) w_next = S_REQ;
      end
      S_REQ: begin
        m_arp_request_valid = 1'b1;
        m_arp_request_ip    = r_ip;
        if (m_arp_request_ready) w_next = S_WAIT;
      end
      S_WAIT: begin
        s_arp_response_valid[r_grant]              = m_arp_response_valid;
        s_arp_response_error[r_grant]              = m_arp_response_error;
        s_arp_response_mac[r_grant*MAC_W +: MAC_W] = m_arp_response_mac;
        m_arp_response_ready = s_arp_response_ready[r_grant];
        // A real response takes priority over a simultaneous expiry.
        if (m_arp_response_valid && s_arp_response_ready[r_grant])
          w_next = S_IDLE;
        else if (w_wd_expire)
          w_next = S_TOUT;
      end
      S_TOUT: begin
        s_arp_response_valid[r_grant] = 1'b1;
        s_arp_response_error[r_grant] = 1'b1;
        if (s_arp_response_ready[r_grant]) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
